// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer for a MIPS-style datapath.
// Owns the instruction register fields, the variable-latency imem handshake,
// PC / register-file write gating, the 2-bit ALU function and a retire counter.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            leave IDLE (sampled only in IDLE)
//   imem_ack, instr  instruction memory handshake and data
//   imem_req         fetch request (high while in FETCH)
//   ir_load          pulse in the cycle instr is captured (follows imem_ack)
//   pc_en, rf_we     one-cycle strobes in WB
//   alu_func         00 add, 01 sub, 10 and, 11 or; valid DECODE..WB
//   rs/rt/rd_addr    instruction register fields
//   busy/halted/err  state indicators; illegal is sticky
//   instr_count      saturating retired-instruction count
module mc_seq_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_we,
  output logic [1:0]       alu_func,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERROR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [14:0]       ir_regs;   // IR[25:11]: the only IR bits consumed after capture
  logic              legal_q;
  logic              ill_q;

  logic [1:0]        dec_func;
  logic              dec_legal;
  logic              dec_illegal;

  // Classify the word on the memory bus so alu_func is already valid in DECODE.
  always_comb begin
    dec_func    = 2'b00;
    dec_legal   = 1'b0;
    dec_illegal = 1'b0;
    if (instr[31:26] == 6'd0) begin
      dec_legal = 1'b1;
      case (instr[5:0])
        6'h20:   dec_func = 2'b00;
        6'h22:   dec_func = 2'b01;
        6'h24:   dec_func = 2'b10;
        6'h25:   dec_func = 2'b11;
        default: begin
          dec_legal   = 1'b0;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // ir_load must coincide with the ack cycle, so it is decoded from the state flop.
  assign ir_load = (state == S_FETCH) && imem_ack;

  assign rs_addr = ir_regs[14:10];
  assign rt_addr = ir_regs[9:5];
  assign rd_addr = ir_regs[4:0];

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      ir_regs     <= '0;
      legal_q     <= 1'b0;
      ill_q       <= 1'b0;
      imem_req    <= 1'b0;
      pc_en       <= 1'b0;
      rf_we       <= 1'b0;
      alu_func    <= 2'b00;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      pc_en <= 1'b0;
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_regs  <= instr[25:11];
            imem_req <= 1'b0;
            if (instr == HALT_WORD) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state    <= S_DECODE;
              alu_func <= dec_func;
              legal_q  <= dec_legal;
              ill_q    <= dec_illegal;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_ERROR;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          illegal <= illegal | ill_q;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_WB;
          pc_en <= 1'b1;
          rf_we <= legal_q && (ir_regs[4:0] != 5'd0);
        end
        S_WB: begin
          if (instr_count != {CNT_W{1'b1}}) begin
            instr_count <= instr_count + CNT_W'(1);
          end
          state    <= S_FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
          alu_func <= 2'b00;
        end
        default: begin
          // HALT and ERROR are terminal until reset.
          state <= state;
        end
      endcase
    end
  end

endmodule
